// File: rtl/gate_share_sched_pkg.sv
// Shared types for gate_share_sched: FSM states, gate opcodes, counter width.
// Latency: n/a (types only). Backpressure: n/a.
// Optional opcode select is enabled in the top by GATE_OP_SEL_EN.
package gate_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GATE_AND  = 2'b00,
        GATE_OR   = 2'b01,
        GATE_XOR  = 2'b10,
        GATE_NAND = 2'b11
    } gate_op_t;

    localparam int OPCNT_W = 8;

    function automatic logic gate_eval(input gate_op_t op, input logic a, input logic b);
        logic r;
        case (op)
            GATE_AND: r = a & b;
            GATE_OR:  r = a | b;
            GATE_XOR: r = a ^ b;
            default:  r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_share_sched_rr_pick.sv
// Round-robin first-set-bit finder: lowest request index at/after ptr, wrapping.
// Latency: combinational. Backpressure: none.
// Out-of-range pointer encodings are treated as 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             any_o,
    output logic [N_REQ-1:0] oh_o,
    output logic [PTR_W-1:0] idx_o
);

    int               base;
    logic [PTR_W-1:0] cand;

    always_comb begin
        any_o = 1'b0;
        oh_o  = '0;
        idx_o = '0;
        cand  = '0;
        base  = (int'(ptr_i) < N_REQ) ? int'(ptr_i) : 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((base + i) % N_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                oh_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_share_sched.sv
// Round-robin scheduler sharing one registered 2-input gate unit among N_REQ requesters.
// Latency: grant 1 cycle after arbitration, response 2 cycles after; min 3 cycles/op.
// Backpressure: response held until winner's rsp_ready_i; opcode select via GATE_OP_SEL_EN.
module gate_share_sched
    import gate_share_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] a_i,
    input  logic [N_REQ*DATA_W-1:0] b_i,
`ifdef GATE_OP_SEL_EN
    input  logic [N_REQ*2-1:0]      op_i,
`endif
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        rsp_valid_o,
    input  logic [N_REQ-1:0]        rsp_ready_i,
    output logic [DATA_W-1:0]       rsp_data_o,
    output logic                    busy_o,
    output logic [OPCNT_W-1:0]      op_count_o
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [OPCNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]    win_oh;
    logic                pick_any;
    logic [N_REQ-1:0]    pick_oh;
    logic [PTR_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   gate_res;
    gate_op_t            op_sel;

`ifdef GATE_OP_SEL_EN
    gate_op_t op_q, op_d;
    assign op_sel = op_q;
`else
    assign op_sel = GATE_AND;
`endif

    rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .oh_o  (pick_oh),
        .idx_o (pick_idx)
    );

    assign win_oh      = N_REQ'(1) << win_q;
    assign gnt_o       = (state_q == EXEC) ? win_oh : '0;
    assign rsp_valid_o = (state_q == RESP) ? win_oh : '0;
    assign rsp_data_o  = res_q;
    assign busy_o      = (state_q != IDLE);
    assign op_count_o  = cnt_q;

    always_comb begin
        gate_res = '0;
        for (int k = 0; k < DATA_W; k++) begin
            gate_res[k] = gate_eval(op_sel, a_q[k], b_q[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
`ifdef GATE_OP_SEL_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                // Operands are captured only here; requesters are free to change them afterwards.
                if (pick_any) begin
                    win_d   = pick_idx;
                    a_d     = a_i[int'(pick_idx)*DATA_W +: DATA_W];
                    b_d     = b_i[int'(pick_idx)*DATA_W +: DATA_W];
`ifdef GATE_OP_SEL_EN
                    op_d    = gate_op_t'(op_i[int'(pick_idx)*2 +: 2]);
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = gate_res;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i[win_q]) begin
                    ptr_d   = (win_q == PTR_W'(N_REQ-1)) ? '0 : win_q + PTR_W'(1);
                    cnt_d   = cnt_q + OPCNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
`ifdef GATE_OP_SEL_EN
            op_q    <= GATE_AND;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
`ifdef GATE_OP_SEL_EN
            op_q    <= op_d;
`endif
        end
    end

endmodule

// File: tb/tb_gate_share_sched.sv
// Bench for gate_share_sched: vector table plus hand sequences, scoreboard on grants/responses.
module tb_gate_share_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] a_i, b_i;
    logic [N-1:0]   gnt_o, rsp_valid_o, rsp_ready_i;
    logic [W-1:0]   rsp_data_o;
    logic           busy_o;
    logic [7:0]     op_count_o;
`ifdef GATE_OP_SEL_EN
    logic [2*N-1:0] op_i;
`endif

    gate_share_sched #(.N_REQ(N), .DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .a_i         (a_i),
        .b_i         (b_i),
`ifdef GATE_OP_SEL_EN
        .op_i        (op_i),
`endif
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o),
        .op_count_o  (op_count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] data;
    } rsp_t;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N-1:0]   rdy;
        logic [N-1:0]   gnt;
        logic [W-1:0]   data;
        logic [7:0]     cnt;
    } vec_t;

    logic [N-1:0] gnt_q[$];
    rsp_t         rsp_q[$];
    int           vec_cnt = 0;
    int           err_cnt = 0;
    logic         chk_spacing = 1'b0;
    int           last_gnt = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_op(input logic [N-1:0] g, input logic [W-1:0] d);
        rsp_t r;
        r.gnt  = g;
        r.data = d;
        gnt_q.push_back(g);
        rsp_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (busy_o && n < max) begin
            step();
            n++;
        end
        if (busy_o) check({tag, "_timeout"}, 32'(busy_o), 0);
    endtask

    // Scoreboard: grants and accepted responses are popped in order of appearance.
    always @(negedge clk) begin
        if (!chk_spacing) last_gnt = -1;
        if (!rst) begin
            if (gnt_o != '0) begin
                if (gnt_q.size() == 0) check("sb_gnt_unexpected", 32'(gnt_o), 0);
                else check("sb_gnt", 32'(gnt_o), 32'(gnt_q.pop_front()));
                if (chk_spacing && last_gnt >= 0) check("gnt_spacing", 32'(cyc - last_gnt), 3);
                last_gnt = cyc;
            end
            if ((rsp_valid_o & rsp_ready_i) != '0) begin
                if (rsp_q.size() == 0) check("sb_rsp_unexpected", 32'(rsp_valid_o), 0);
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("sb_rsp_valid", 32'(rsp_valid_o), 32'(r.gnt));
                    check("sb_rsp_data", 32'(rsp_data_o), 32'(r.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t tbl[7];

    initial begin
        bit seen255;
        tbl[0] = '{4'b0001, 16'h5A3C, 16'h963A, 4'b1111, 4'b0001, 4'h8, 8'd1};
        tbl[1] = '{4'b1000, 16'h7F00, 16'hD0FF, 4'b1111, 4'b1000, 4'h5, 8'd2};
        tbl[2] = '{4'b1000, 16'hF123, 16'h3FFF, 4'b1111, 4'b1000, 4'h3, 8'd3};
        tbl[3] = '{4'b0110, 16'h00A0, 16'hF0F0, 4'b0010, 4'b0010, 4'hA, 8'd4};
        tbl[4] = '{4'b0011, 16'hFFF6, 16'h0005, 4'b0001, 4'b0001, 4'h4, 8'd5};
        tbl[5] = '{4'b1111, 16'h0090, 16'h00B0, 4'b1111, 4'b0010, 4'h9, 8'd6};
        tbl[6] = '{4'b0101, 16'h0E00, 16'h0700, 4'b1111, 4'b0100, 4'h6, 8'd7};

        rst = 1'b1; req_i = '0; a_i = '0; b_i = '0; rsp_ready_i = '0;
`ifdef GATE_OP_SEL_EN
        op_i = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_valid", 32'(rsp_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_count", 32'(op_count_o), 0);
        check("rst_data", 32'(rsp_data_o), 0);
        rst = 1'b0;

        // Table: arbitration order, wrap of pointer, operand slice selection, exact timing.
        for (int i = 0; i < 7; i++) begin
            req_i = tbl[i].req; a_i = tbl[i].a; b_i = tbl[i].b; rsp_ready_i = tbl[i].rdy;
            expect_op(tbl[i].gnt, tbl[i].data);
            step();
            req_i = '0; a_i = '0; b_i = '0;
            check("vec_gnt", 32'(gnt_o), 32'(tbl[i].gnt));
            check("vec_busy", 32'(busy_o), 1);
            step();
            check("vec_valid", 32'(rsp_valid_o), 32'(tbl[i].gnt));
            check("vec_data", 32'(rsp_data_o), 32'(tbl[i].data));
            wait_idle(10, "vec_done");
            check("vec_count", 32'(op_count_o), 32'(tbl[i].cnt));
        end

        // Held requests rotate fairly, one grant every 3 cycles.
        rst = 1'b1; step(); rst = 1'b0;
        chk_spacing = 1'b1;
        expect_op(4'b0001, 4'h4); expect_op(4'b0010, 4'h3); expect_op(4'b0100, 4'h2);
        expect_op(4'b1000, 4'h1); expect_op(4'b0001, 4'h4);
        req_i = 4'b1111; a_i = 16'hFFFF; b_i = 16'h1234; rsp_ready_i = 4'b1111;
        for (int n = 0; n < 40 && op_count_o != 8'd5; n++) step();
        req_i = '0;
        chk_spacing = 1'b0;
        check("rr_count", 32'(op_count_o), 5);

        // Stalled response on requester 2; other readies are ignored.
        req_i = 4'b0100; a_i = 16'h0B00; b_i = 16'h0E00; rsp_ready_i = 4'b1011;
        expect_op(4'b0100, 4'hA);
        step(); req_i = '0; a_i = '0; b_i = '0;
        step();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(rsp_valid_o), 32'(4'b0100));
            check("stall_data", 32'(rsp_data_o), 32'hA);
            step();
        end
        rsp_ready_i = 4'b1111;
        wait_idle(5, "stall_done");
        check("stall_count", 32'(op_count_o), 6);

        // Reset during RESP discards the response and clears the pointer.
        req_i = 4'b0001; a_i = 16'h000F; b_i = 16'h0003; rsp_ready_i = '0;
        gnt_q.push_back(4'b0001);
        step(); req_i = '0;
        step();
        check("mid_valid", 32'(rsp_valid_o), 32'(4'b0001));
        rst = 1'b1; step(); rst = 1'b0;
        check("mrst_gnt", 32'(gnt_o), 0);
        check("mrst_valid", 32'(rsp_valid_o), 0);
        check("mrst_busy", 32'(busy_o), 0);
        check("mrst_count", 32'(op_count_o), 0);
        check("mrst_data", 32'(rsp_data_o), 0);
        req_i = 4'b0110; a_i = 16'h00F0; b_i = 16'h0050; rsp_ready_i = 4'b1111;
        expect_op(4'b0010, 4'h5);
        step(); req_i = '0;
        check("mrst_regnt", 32'(gnt_o), 32'(4'b0010));
        wait_idle(10, "mrst_done");
        check("mrst_count1", 32'(op_count_o), 1);

        // Counter wrap: 255 more operations bring it from 1 back to 0.
        chk_spacing = 1'b1;
        for (int i = 0; i < 255; i++) begin
            int w;
            w = (2 + i) % 4;
            expect_op(4'(1 << w), 4'(4 - w));
        end
        seen255 = 1'b0;
        req_i = 4'b1111; a_i = 16'hFFFF; b_i = 16'h1234; rsp_ready_i = 4'b1111;
        for (int n = 0; n < 1500; n++) begin
            step();
            if (op_count_o == 8'd255) seen255 = 1'b1;
            if (op_count_o == 8'd0) break;
        end
        req_i = '0;
        chk_spacing = 1'b0;
        check("wrap_seen255", 32'(seen255), 1);
        check("wrap_count", 32'(op_count_o), 0);
        wait_idle(10, "wrap_idle");

`ifdef GATE_OP_SEL_EN
        req_i = 4'b0001; op_i = 8'b0000_0010; a_i = 16'h000C; b_i = 16'h000A; rsp_ready_i = 4'b1111;
        expect_op(4'b0001, 4'h6);
        step(); req_i = '0; op_i = '0;
        step();
        check("xor_data", 32'(rsp_data_o), 32'h6);
        wait_idle(10, "xor_done");
`endif

        step();
        check("sb_gnt_drained", 32'(gnt_q.size()), 0);
        check("sb_rsp_drained", 32'(rsp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
